adc_emu: RTL
============

Name: adc_emu

Overview:
- Synthesizable responder for the 8-channel, 12-bit serial ADC interface: the ADC-chip end of the ADC_CS_N/ADC_SCLK/ADC_DIN/ADC_DOUT link.
- Lets the oscilloscope's ADC reader and display path run on the board or in simulation with no physical converter attached.
- Oversamples the serial pins on the system clock, decodes the channel address, and shifts back the 12-bit sample of the previously addressed channel.

Parameters:
- DATA_W, 12, sample width; frame is 4 leading zeros + DATA_W = 16 bits.
- SYNC_STAGES, 2, synchronizer flops on ADC_CS_N, ADC_SCLK and ADC_DIN (minimum 2).
- PAT_STEP, 16, triangle-pattern increment per completed frame (used only with the optional feature).

Ports:
- clk  input  1  system clock; ADC_SCLK half-period must be at least 4 clk periods.
- reset  input  1  synchronous, active-high reset.
- ADC_CS_N  input  1  chip select, active low, asynchronous to clk.
- ADC_SCLK  input  1  serial clock from the initiator, asynchronous to clk.
- ADC_DIN  input  1  control bits from the initiator; sampled on rising ADC_SCLK.
- ADC_DOUT  output  1  sample bits to the initiator; changes after falling ADC_SCLK.
- chan_data  input  8x12 packed (96)  sample value per channel; channel n occupies bits [12n+11:12n].
- cur_chan  output  3  channel being converted in the current frame.
- frame_done  output  1  one-clk pulse after the 16th rising ADC_SCLK edge of a frame.
- abort_err  output  1  sticky flag: ADC_CS_N deasserted mid-frame.

Behaviour:
- Reset values: ADC_DOUT=0, cur_chan=0, frame_done=0, abort_err=0. Internally: next channel=0, bit counter=0, state IDLE.
- Synchronization and edge detection:
  - All three pins pass through SYNC_STAGES flops.
  - Rise and fall of ADC_SCLK are detected from the last two synchronized samples.
  - ADC_DOUT is registered. Latency from pin edge to ADC_DOUT change is SYNC_STAGES+1 clk (3 by default).
- States:
  - IDLE: CS_N high. ADC_DOUT=0. SCLK edges are ignored.
  - SHIFT:
    - Entered on synchronized CS_N fall. On entry: cur_chan<=next channel, bit counter=0, ADC_DOUT=bit15 (0).
    - Rising edge k (k=1..16): counter=k.
    - Rising edges 3, 4, 5 capture DIN into ADD2, ADD1, ADD0 (word bits 13..11). After edge 5, next channel<=ADD[2:0].
    - Falling edge 3 latches chan_data[cur_chan] into the shift register.
    - Falling edge k (k=1..15) drives word bit 15-k. Word = {4'b0, sample}, so bit 11 (MSB) appears after falling edge 4 and bit 0 after falling edge 15.
    - At the 16th rising edge: frame_done pulses. If CS_N is still low, a new frame starts immediately (continuous conversion): counter=0, cur_chan<=next channel, ADC_DOUT=0.
- Boundary conditions:
  - CS_N rise before the 16th rising edge: go to IDLE, ADC_DOUT=0, abort_err<=1, no frame_done.
    - If the abort happens before rising edge 5, next channel is unchanged.
    - If the abort happens at or after edge 5, the captured address is kept.
  - CS_N rise on the same clk as the 16th-rise detection: the frame counts as complete (frame_done=1, no abort).
  - SCLK edges while CS_N is high: no effect.
  - DIN bits other than 13..11: ignored.
  - chan_data changes after falling edge 3: no effect on the current frame.
  - reset asserted mid-frame: all state returns to reset values on the next clk, regardless of pin levels. After reset is released, a frame starts only on a fresh CS_N fall.

Optional Feature:
- Macro: ADC_EMU_PATTERN_EN.
- When defined, channel 0 ignores chan_data[0] and returns an internal 12-bit triangle generator:
  - Reset value 0, direction up.
  - Steps by PAT_STEP on each frame_done whose cur_chan=0.
  - Going up, clamps at 4095 and reverses; going down, clamps at 0 and reverses.
  - The value latched at falling edge 3 is the generator value at that time.
- When not defined: no generator logic; channel 0 behaves like channels 1-7.

Test Plan:
- Reset held 4 clk, then released with CS_N high and SCLK toggling -> ADC_DOUT=0, cur_chan=0, frame_done=0, abort_err=0 throughout.
- chan_data[0]=12'hA5C; one 16-SCLK frame with DIN word 16'h0000 (SCLK half-period 8 clk) -> DOUT word captured on rising edges = 16'h0A5C; one frame_done pulse; next channel remains 0.
- Frame 1 with DIN 16'h1800 (address 3), chan_data[3]=12'h123; frame 2 with DIN 0 -> frame 2 returns 16'h0123 with cur_chan=3; frame 3 returns chan_data[0].
- CS_N held low for 32 SCLK, DIN 16'h3800 in the first word -> two words returned (ch0, then ch7); frame_done pulses twice; ADC_DOUT=0 at bits 15..12 of word 2.
- CS_N raised after 7 rising edges with DIN address 5 -> abort_err=1 (sticky); ADC_DOUT=0 within 3 clk; no frame_done; next frame converts channel 5. Repeat with abort after 2 edges -> channel unchanged.
- ADC_EMU_PATTERN_EN defined, PAT_STEP=16, channel-0 frames -> words 0x000, 0x010, 0x020, ...; at 0xFF0 then 0xFFF, the next value is 0xFEF.

Source files
------------

// File: rtl/adc_emu.sv
// ADC-chip end of the 8-channel 12-bit serial ADC link, oversampled on clk.
// Optional: ADC_EMU_PATTERN_EN replaces channel 0 with an internal triangle generator.
module adc_emu #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PAT_STEP    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ADC_CS_N,
  input  logic                  ADC_SCLK,
  input  logic                  ADC_DIN,
  output logic                  ADC_DOUT,
  input  logic [8*DATA_W-1:0]   chan_data,
  output logic [2:0]            cur_chan,
  output logic                  frame_done,
  output logic                  abort_err
);

  localparam int unsigned NCH       = 8;
  localparam int unsigned FRAME_LEN = DATA_W + 4;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s, din_s;
  logic                   sclk_rise_c, sclk_fall_c, cs_fall_c, frame_end_c;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             addr;
  logic [2:0]             next_chan;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      chan_arr [NCH];
  logic [DATA_W-1:0]      sel_sample_c;

  // Pin synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      din_sync  <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], ADC_DIN};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];

  // CS history resets low so a pin already low at reset release is not seen as a fall.
  assign sclk_rise_c = sclk_s & ~sclk_prev;
  assign sclk_fall_c = ~sclk_s & sclk_prev;
  assign cs_fall_c   = cs_prev & ~cs_s;
  assign frame_end_c = (state == SHIFT) && sclk_rise_c && (cnt == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      chan_arr[n] = chan_data[n*DATA_W +: DATA_W];
    end
  end

`ifdef ADC_EMU_PATTERN_EN
  localparam logic [DATA_W-1:0] PAT_MAX = {DATA_W{1'b1}};

  logic [DATA_W-1:0] pat;
  logic              pat_down;
  logic [DATA_W:0]   pat_up_sum_c;

  assign pat_up_sum_c = {1'b0, pat} + (DATA_W+1)'(PAT_STEP);

  // Triangle generator, stepped once per completed channel-0 frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat      <= '0;
      pat_down <= 1'b0;
    end else if (frame_end_c && (cur_chan == 3'd0)) begin
      if (!pat_down) begin
        if (pat_up_sum_c > {1'b0, PAT_MAX}) begin
          pat      <= PAT_MAX;
          pat_down <= 1'b1;
        end else begin
          pat <= pat_up_sum_c[DATA_W-1:0];
        end
      end else begin
        if (pat < DATA_W'(PAT_STEP)) begin
          pat      <= '0;
          pat_down <= 1'b0;
        end else begin
          pat <= pat - DATA_W'(PAT_STEP);
        end
      end
    end
  end

  assign sel_sample_c = (cur_chan == 3'd0) ? pat : chan_arr[cur_chan];
`else
  assign sel_sample_c = chan_arr[cur_chan];
`endif

  // Frame FSM: counter tracks rising edges, falling edges move the output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      next_chan  <= '0;
      shreg      <= '0;
      ADC_DOUT   <= 1'b0;
      cur_chan   <= '0;
      frame_done <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          ADC_DOUT <= 1'b0;
          if (cs_fall_c) begin
            state    <= SHIFT;
            cnt      <= '0;
            cur_chan <= next_chan;
          end
        end
        SHIFT: begin
          if (frame_end_c) begin
            frame_done <= 1'b1;
            cnt        <= '0;
            ADC_DOUT   <= 1'b0;
            if (cs_s) begin
              state <= IDLE;
            end else begin
              cur_chan <= next_chan;
            end
          end else if (cs_s) begin
            // A frame that has seen no rising edge carried no data, so leaving it is not an abort.
            state    <= IDLE;
            ADC_DOUT <= 1'b0;
            if (cnt != '0) begin
              abort_err <= 1'b1;
            end
          end else if (sclk_rise_c) begin
            cnt <= cnt + CNT_W'(1);
            case (cnt)
              CNT_W'(2): addr[1]   <= din_s;
              CNT_W'(3): addr[0]   <= din_s;
              CNT_W'(4): next_chan <= {addr, din_s};
              default: ;
            endcase
          end else if (sclk_fall_c) begin
            if (cnt == CNT_W'(3)) begin
              shreg    <= sel_sample_c;
              ADC_DOUT <= 1'b0;
            end else if (cnt >= CNT_W'(4)) begin
              ADC_DOUT <= shreg[DATA_W-1];
              shreg    <= {shreg[DATA_W-2:0], 1'b0};
            end else begin
              ADC_DOUT <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
